mem_lsu_stage: RTL
==================

Name: mem_lsu_stage

Overview:
- Parametrised load/store unit for the MEM pipeline stage. It is the successor of the single-cycle MEM stage.
- Adds byte-lane store steering with byte enables, so stores never zero-fill neighbouring bytes. Loads extract the sub-word at the correct offset.
- Detects misaligned, illegal and out-of-range accesses.
- Supports a configurable memory latency with a stall handshake to the pipeline, plus a registered debug-unit read port.

Parameters:
- NB_WIDTH, 32, data word width; fixed at 4 byte lanes.
- NB_ADDR, 9, byte-address width of data memory; depth is 2^NB_ADDR bytes.
- MEM_LAT, 1, access latency in cycles; legal range 1..8.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  stage holds a valid instruction
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_bhw  in  3  size/sign code
- i_addr  in  NB_WIDTH  byte address (ALU result)
- i_wdata  in  NB_WIDTH  store data (rt)
- i_dunit_addr  in  NB_ADDR  debug byte address; bits [1:0] ignored
- o_rdata  out  NB_WIDTH  extended load result
- o_done  out  1  one-cycle pulse, access complete
- o_stall  out  1  freeze upstream pipeline registers
- o_fault  out  1  one-cycle pulse, access rejected
- o_fault_cause  out  2  01 misaligned, 10 illegal, 11 out of range
- o_fault_addr  out  NB_WIDTH  offending i_addr
- o_dunit_data  out  NB_WIDTH  debug word read

Behaviour:
- Clock/reset: clock i_clk; reset i_reset, synchronous, active-high.
  - Reset values: o_rdata=0, o_done=0, o_stall=0, o_fault=0, o_fault_cause=0, o_fault_addr=0, o_dunit_data=0, FSM=IDLE, counter=0.
  - Memory contents are not reset (BRAM inference).
- i_bhw codes:
  - 000 B signed, 001 H signed, 011 W, 100 BU, 101 HU.
  - Any other code is illegal.
- Request: i_valid & (i_mem_read | i_mem_write), evaluated only in IDLE. Call the cycle it is accepted T.
- Fault check in cycle T, in priority order:
  - read & write both set, or illegal i_bhw -> 10.
  - i_addr[NB_WIDTH-1:NB_ADDR] != 0 -> 11.
  - H/HU with addr[0]=1, or W with addr[1:0]!=0 -> 01.
- Faulted request:
  - No memory access, no stall.
  - T+1: o_fault=1 with cause and address registered.
  - o_done stays 0; o_rdata holds its previous value.
- FSM IDLE/BUSY, with cnt = clog2(MEM_LAT+1) bits:
  - IDLE -> BUSY on an accepted request when MEM_LAT>1, cnt=MEM_LAT-1.
  - BUSY decrements cnt; returns to IDLE when cnt==1.
  - MEM_LAT=1 never leaves IDLE.
- o_stall: asserted cycles T..T+L-2 (L = MEM_LAT).
  - In T it is combinational from the request; in BUSY it is asserted while cnt>1.
  - L=1 gives zero stall cycles.
  - Inputs are stable while stalled; the pipeline advances at the edge ending T+L-1.
- Store: byte-enabled write commits at the edge ending T+L-1.
  - SB: lane addr[1:0] <= wdata[7:0].
  - SH: lanes {addr[1],0..1} <= wdata[15:0].
  - SW: all lanes.
  - Byte order is little-endian: lane 0 = bits [7:0].
- Load: word read; select byte/halfword at the offset; sign- or zero-extend. Registered into o_rdata at the edge ending T+L-1.
- o_done: high in cycle T+L for one cycle, for loads and stores. o_rdata holds until the next load completes.
- Back-to-back: a new request may be accepted in cycle T+L.
- Read and write to the same address in consecutive requests: the load returns the newly stored data.
- Debug port: o_dunit_data <= word at i_dunit_addr[NB_ADDR-1:2], one-cycle latency. It is independent of the FSM; reads on the same edge as a store return old data.
- Reset mid-access: a pending store is dropped, the FSM returns to IDLE, and all outputs are cleared.
- i_valid low while BUSY: no effect; the access completes.

Decomposition:
- Package mem_lsu_pkg:
  - BHW code localparams.
  - Fault cause codes.
  - FSM state encoding.
  - Function for load extract/extend.
  - Function for store byte-enable/lane-steer.
- Sub-module lsu_byte_lane_ram:
  - 4 x byte lanes, 2^(NB_ADDR-2) words.
  - Per-lane write enable.
  - Synchronous read port plus a second synchronous debug read port.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> o_rdata=0xDEADBEEF, o_done at T+1, o_stall never high.
- SB 0x80 @0x13 -> LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080; LW @0x10 = 0x80ADBEEF.
- SH 0x8001 @0x22 -> LH = 0xFFFF8001, LHU = 0x00008001; then LH @0x21 -> o_fault=1, cause 01, addr 0x21, no o_done, word @0x20 unchanged.
- MEM_LAT=3, LW @0x10 -> o_stall high 2 cycles (T, T+1), o_done at T+3; second LW accepted at T+3 -> done at T+6.
- MEM_LAT=3, SW 0x12345678 @0x30 with reset at T+1 -> outputs all 0, later LW @0x30 returns the prior content, not 0x12345678.
- Debug addr 0x13 -> o_dunit_data=0x80ADBEEF next cycle; LW @0x400 (NB_ADDR=9) -> fault 11; i_bhw=111 -> fault 10.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, fault causes,
// FSM encoding and the lane steering / extraction helpers.
package mem_lsu_pkg;

  localparam int unsigned LSU_LANES  = 4;
  localparam int unsigned LSU_WORD_W = 32;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b011;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_RANGE    = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic [LSU_LANES-1:0]  be;
    logic [LSU_WORD_W-1:0] data;
  } store_lane_t;

  function automatic logic bhw_legal(input logic [2:0] bhw);
    case (bhw)
      BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU: bhw_legal = 1'b1;
      default:                             bhw_legal = 1'b0;
    endcase
  endfunction

  function automatic logic bhw_misaligned(input logic [2:0] bhw, input logic [1:0] off);
    case (bhw)
      BHW_H, BHW_HU: bhw_misaligned = off[0];
      BHW_W:         bhw_misaligned = |off;
      default:       bhw_misaligned = 1'b0;
    endcase
  endfunction

  // Pick the byte/halfword at the offset and sign- or zero-extend it.
  function automatic logic [LSU_WORD_W-1:0] load_extract(input logic [LSU_WORD_W-1:0] word,
                                                         input logic [1:0]            off,
                                                         input logic [2:0]            bhw);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (bhw)
      BHW_B:   load_extract = {{24{b[7]}}, b};
      BHW_BU:  load_extract = {24'd0, b};
      BHW_H:   load_extract = {{16{h[15]}}, h};
      BHW_HU:  load_extract = {16'd0, h};
      BHW_W:   load_extract = word;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Replicate store data across lanes; only the enabled lanes get written.
  function automatic store_lane_t store_steer(input logic [1:0]            off,
                                              input logic [2:0]            bhw,
                                              input logic [LSU_WORD_W-1:0] wdata);
    store_lane_t s;
    case (bhw)
      BHW_B, BHW_BU: begin
        s.be   = 4'b0001 << off;
        s.data = {4{wdata[7:0]}};
      end
      BHW_H, BHW_HU: begin
        s.be   = off[1] ? 4'b1100 : 4'b0011;
        s.data = {2{wdata[15:0]}};
      end
      BHW_W: begin
        s.be   = 4'b1111;
        s.data = wdata;
      end
      default: begin
        s.be   = 4'b0000;
        s.data = 32'd0;
      end
    endcase
    store_steer = s;
  endfunction

endpackage

// File: rtl/lsu_byte_lane_ram.sv
// Four independent byte-lane memories with per-lane write enables, a synchronous
// access read port and a synchronous, read-first debug port.
module lsu_byte_lane_ram #(
  parameter int NB_ADDR = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_ADDR-3:0] i_addr,
  input  logic [3:0]         i_we,
  input  logic [31:0]        i_wdata,
  input  logic               i_re,
  output logic [31:0]        o_rdata,
  input  logic [NB_ADDR-3:0] i_dbg_addr,
  output logic [31:0]        o_dbg_data
);

  localparam int DEPTH = 2 ** (NB_ADDR - 2);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q, rd_d;
    logic [7:0] dbg_q, dbg_d;

    always_ff @(posedge i_clk) begin
      if (i_we[g]) begin
        mem_q[i_addr] <= i_wdata[8*g +: 8];
      end
    end

    always_comb begin
      rd_d  = rd_q;
      dbg_d = mem_q[i_dbg_addr];
      if (i_re) begin
        rd_d = mem_q[i_addr];
      end else begin
        rd_d = rd_q;
      end
    end

    // Output registers clear on reset; the array itself is never reset.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        rd_q  <= 8'd0;
        dbg_q <= 8'd0;
      end else begin
        rd_q  <= rd_d;
        dbg_q <= dbg_d;
      end
    end

    assign o_rdata[8*g +: 8]    = rd_q;
    assign o_dbg_data[8*g +: 8] = dbg_q;
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: fault screening, latency FSM with pipeline stall,
// byte-lane store steering and extended load results.
module mem_lsu_stage
  import mem_lsu_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int MEM_LAT  = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [2:0]          i_bhw,
  input  logic [NB_WIDTH-1:0] i_addr,
  input  logic [NB_WIDTH-1:0] i_wdata,
  input  logic [NB_ADDR-1:0]  i_dunit_addr,
  output logic [NB_WIDTH-1:0] o_rdata,
  output logic                o_done,
  output logic                o_stall,
  output logic                o_fault,
  output logic [1:0]          o_fault_cause,
  output logic [NB_WIDTH-1:0] o_fault_addr,
  output logic [NB_WIDTH-1:0] o_dunit_data
);

  localparam int NB_CNT = $clog2(MEM_LAT + 1);

  typedef struct packed {
    logic                is_write;
    logic [2:0]          bhw;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_WIDTH-1:0] wdata;
  } lsu_op_t;

  lsu_state_e          state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  lsu_op_t             op_q, op_d, cur_op_s;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic [1:0]          cause_q, cause_d;
  logic [NB_WIDTH-1:0] faddr_q, faddr_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic [2:0]          ld_bhw_q, ld_bhw_d;

  logic                req_s, accept_s, reject_s, last_s, stall_s;
  logic [1:0]          cause_s;
  store_lane_t         steer_s;
  logic [3:0]          ram_we_s;
  logic                ram_re_s;
  logic [31:0]         ram_rdata_s;
  logic                unused_s;

  assign unused_s = ^i_dunit_addr[1:0];
  assign req_s    = i_valid & (i_mem_read | i_mem_write);

  // Fault classification, highest priority first.
  always_comb begin
    cause_s = CAUSE_NONE;
    if ((i_mem_read & i_mem_write) | ~bhw_legal(i_bhw)) begin
      cause_s = CAUSE_ILLEGAL;
    end else if (|i_addr[NB_WIDTH-1:NB_ADDR]) begin
      cause_s = CAUSE_RANGE;
    end else if (bhw_misaligned(i_bhw, i_addr[1:0])) begin
      cause_s = CAUSE_MISALIGN;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  assign accept_s = (state_q == ST_IDLE) & req_s & (cause_s == CAUSE_NONE);
  assign reject_s = (state_q == ST_IDLE) & req_s & (cause_s != CAUSE_NONE);

  // Latency FSM: last_s marks the cycle whose closing edge performs the access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cur_op_s = op_q;
    last_s   = 1'b0;
    stall_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cur_op_s = '{is_write: i_mem_write, bhw: i_bhw,
                     addr: i_addr[NB_ADDR-1:0], wdata: i_wdata};
        if (accept_s) begin
          if (MEM_LAT > 1) begin
            state_d = ST_BUSY;
            cnt_d   = NB_CNT'(MEM_LAT - 1);
            op_d    = cur_op_s;
            stall_s = 1'b1;
          end else begin
            last_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d   = cnt_q - NB_CNT'(1);
        stall_s = (cnt_q > NB_CNT'(1));
        if (cnt_q == NB_CNT'(1)) begin
          state_d = ST_IDLE;
          last_s  = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign steer_s  = store_steer(cur_op_s.addr[1:0], cur_op_s.bhw, cur_op_s.wdata[31:0]);
  assign ram_we_s = (last_s & cur_op_s.is_write & ~i_reset) ? steer_s.be : 4'b0000;
  assign ram_re_s = last_s & ~cur_op_s.is_write & ~i_reset;

  // Completion/fault pulses and the extraction context of the last load.
  always_comb begin
    done_d   = last_s;
    fault_d  = reject_s;
    cause_d  = cause_q;
    faddr_d  = faddr_q;
    ld_off_d = ld_off_q;
    ld_bhw_d = ld_bhw_q;
    if (reject_s) begin
      cause_d = cause_s;
      faddr_d = i_addr;
    end else begin
      cause_d = cause_q;
    end
    if (ram_re_s) begin
      ld_off_d = cur_op_s.addr[1:0];
      ld_bhw_d = cur_op_s.bhw;
    end else begin
      ld_off_d = ld_off_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      faddr_q  <= '0;
      ld_off_q <= 2'b00;
      ld_bhw_q <= BHW_W;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      faddr_q  <= faddr_d;
      ld_off_q <= ld_off_d;
      ld_bhw_q <= ld_bhw_d;
    end
  end

  lsu_byte_lane_ram #(
    .NB_ADDR(NB_ADDR)
  ) u_ram (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_addr     (cur_op_s.addr[NB_ADDR-1:2]),
    .i_we       (ram_we_s),
    .i_wdata    (steer_s.data),
    .i_re       (ram_re_s),
    .o_rdata    (ram_rdata_s),
    .i_dbg_addr (i_dunit_addr[NB_ADDR-1:2]),
    .o_dbg_data (o_dunit_data)
  );

  // The RAM word register only moves on load completion, so o_rdata holds between loads.
  assign o_rdata       = load_extract(ram_rdata_s, ld_off_q, ld_bhw_q);
  assign o_done        = done_q;
  assign o_stall       = stall_s;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;
  assign o_fault_addr  = faddr_q;

endmodule
